// File: rtl/idelay_pkg.sv
// Shared types and helpers for the multi-channel IDELAYE3 load sequencer.
package idelay_pkg;

    // Tap value width of the IDELAYE3 CNTVALUEIN/CNTVALUEOUT buses.
    localparam int TAP_W  = 9;
    // Upper bound on channel count; the scan helper works on a vector this wide.
    localparam int MAX_CH = 32;
    // Width of the shared wait counter.
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_VTC_OFF,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_VTC_ON
    } state_t;

    // Result of a round-robin scan: whether a channel was found, and which one.
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // Return the first set bit of mism, visiting channels start, start+1, ...
    // wrapping at num_ch. Bits at or above num_ch are never considered.
    function automatic pick_t find_next_mismatch(
        input logic [MAX_CH-1:0] mism,
        input int                num_ch,
        input int                start
    );
        pick_t r;
        int    c;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            c = start + k;
            if (c >= num_ch) c = c - num_ch;
            if ((k < num_ch) && !r.found && mism[c[4:0]]) begin
                r.found = 1'b1;
                r.idx   = c[4:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/idelay_lane.sv
// One input-delay lane: behavioural stand-in for an IDELAYE3 in VAR_LOAD /
// COUNT mode. The tap register only accepts a LOAD while EN_VTC is low, as
// the primitive does; the data path is passed through undelayed.
module idelay_lane #(
    parameter real CLOCK_FREQ = 250.0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en_vtc,
    input  logic                       i_load,
    input  logic [idelay_pkg::TAP_W-1:0] i_cntvalue,
    output logic [idelay_pkg::TAP_W-1:0] o_cntvalue,
    input  logic                       i_d,
    output logic                       o_q
);
    import idelay_pkg::*;

    if ((CLOCK_FREQ < 200.0) || (CLOCK_FREQ > 2667.0)) begin : g_bad_freq
        $error("idelay_lane: CLOCK_FREQ outside the IDELAYCTRL reference range");
    end

    logic [TAP_W-1:0] r_tap;

    // Tap register: cleared by the primitive reset, loaded while VT tracking is off.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap <= '0;
        end else if (i_load && !i_en_vtc) begin
            r_tap <= i_cntvalue;
        end
    end

    assign o_cntvalue = r_tap;
    assign o_q        = i_d;

endmodule

// File: rtl/idelay_bank_seq.sv
// Multi-channel input-delay load sequencer. One shared engine scans channels
// round-robin, loads any tap whose request differs from the committed value,
// then verifies it by reading CNTVALUEOUT back.
module idelay_bank_seq #(
    parameter int  NUM_CH     = 8,
    parameter real CLOCK_FREQ = 250.0,
    parameter int  TAP_W      = idelay_pkg::TAP_W,
    parameter int  SETUP_WAIT = 20,
    parameter int  HOLD_WAIT  = 20,
    parameter int  VTC_HOLD   = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [NUM_CH-1:0]       d,
    output logic [NUM_CH-1:0]       q,
    input  logic [NUM_CH*TAP_W-1:0] load_value,
    output logic [NUM_CH*TAP_W-1:0] delay_value,
    output logic                    done,
    output logic                    busy,
    output logic [CH_W-1:0]         cur_ch,
    output logic [NUM_CH-1:0]       err,
    input  logic                    err_clr
);
    import idelay_pkg::*;

    if ((NUM_CH < 1) || (NUM_CH > MAX_CH)) begin : g_bad_num_ch
        $error("idelay_bank_seq: NUM_CH must be 1..32");
    end
    if ((SETUP_WAIT < 0) || (SETUP_WAIT > 255)) begin : g_bad_setup
        $error("idelay_bank_seq: SETUP_WAIT must fit the 8-bit counter");
    end
    if ((HOLD_WAIT < 0) || (HOLD_WAIT > 255)) begin : g_bad_hold
        $error("idelay_bank_seq: HOLD_WAIT must fit the 8-bit counter");
    end
    if (TAP_W != idelay_pkg::TAP_W) begin : g_bad_tap_w
        $error("idelay_bank_seq: TAP_W is fixed by the IDELAYE3 primitive");
    end

    // Extra cycles spent in VTC_ON after EN_VTC is raised again.
    localparam logic [CNT_W-1:0] VTC_ON_WAIT = (VTC_HOLD != 0) ? CNT_W'(0) : CNT_W'(4);

    state_t              r_state;
    logic [CH_W-1:0]     r_cur_ch;
    logic [TAP_W-1:0]    r_target;
    logic [CNT_W-1:0]    r_cnt;
    logic [TAP_W-1:0]    r_commit [NUM_CH];
    logic [NUM_CH-1:0]   r_en_vtc;
    logic [NUM_CH-1:0]   r_load;
    logic [NUM_CH-1:0]   r_err;
    logic                r_busy;
    logic                r_done;

    logic [NUM_CH*TAP_W-1:0] w_cntout;
    logic [TAP_W-1:0]        w_req [NUM_CH];
    logic [TAP_W-1:0]        w_rb  [NUM_CH];
    logic [MAX_CH-1:0]       w_mism;
    int                      w_start;
    pick_t                   w_pick;
    logic                    w_pick_valid;
    logic [CH_W-1:0]         w_pick_ch;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        assign w_req[gi] = load_value[gi*TAP_W +: TAP_W];
        assign w_rb[gi]  = w_cntout[gi*TAP_W +: TAP_W];

        idelay_lane #(
            .CLOCK_FREQ (CLOCK_FREQ)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_en_vtc   (r_en_vtc[gi]),
            .i_load     (r_load[gi]),
            .i_cntvalue (r_target),
            .o_cntvalue (w_cntout[gi*TAP_W +: TAP_W]),
            .i_d        (d[gi]),
            .o_q        (q[gi])
        );
    end

    // Flag every channel whose request differs from its committed tap.
    // NOTE: the default assignment first keeps this combinational block free of latches.
    always_comb begin
        w_mism = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_mism[i] = (r_commit[i] != w_req[i]);
        end
    end

    // Scan begins one past the channel serviced last, so service rotates fairly.
    assign w_start      = ((int'(r_cur_ch) + 1) >= NUM_CH) ? 0 : (int'(r_cur_ch) + 1);
    assign w_pick       = find_next_mismatch(w_mism, NUM_CH, w_start);
    assign w_pick_valid = w_pick.found && (int'(w_pick.idx) < NUM_CH);
    assign w_pick_ch    = w_pick.idx[CH_W-1:0];

    // Load engine FSM with all control outputs registered.
    // NOTE: the committed mirror is a small flop array, not RAM, so it takes the
    // async reset together with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RESET;
            r_cur_ch <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < NUM_CH; i++) r_commit[i] <= '0;
            r_en_vtc <= '1;
            r_load   <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_load <= '0;
            // A clear is overridden below if CHECK flags a new error in the same cycle.
            if (err_clr) r_err <= '0;

            if (!rdy) begin
                // Calibration lost: drop everything and reload all taps once it returns.
                r_state  <= ST_RESET;
                for (int i = 0; i < NUM_CH; i++) r_commit[i] <= '0;
                r_en_vtc <= '1;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET: begin
                        r_state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (w_pick_valid) begin
                            r_cur_ch            <= w_pick_ch;
                            r_target            <= w_req[w_pick_ch];
                            r_cnt               <= CNT_W'(SETUP_WAIT);
                            r_en_vtc[w_pick_ch] <= 1'b0;
                            r_busy              <= 1'b1;
                            r_done              <= 1'b0;
                            r_state             <= ST_VTC_OFF;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                    ST_VTC_OFF: begin
                        if (r_cnt == '0) begin
                            r_load[r_cur_ch] <= 1'b1;
                            r_state          <= ST_LOAD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        r_cnt   <= CNT_W'(HOLD_WAIT);
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        r_commit[r_cur_ch] <= r_target;
                        if (w_rb[r_cur_ch] != r_target) r_err[r_cur_ch] <= 1'b1;
                        r_cnt   <= VTC_ON_WAIT;
                        r_state <= ST_VTC_ON;
                    end
                    ST_VTC_ON: begin
                        if (VTC_HOLD == 0) r_en_vtc[r_cur_ch] <= 1'b1;
                        if (r_cnt == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_RESET;
                    end
                endcase
            end
        end
    end

    assign delay_value = w_cntout;
    assign done        = r_done;
    assign busy        = r_busy;
    assign cur_ch      = r_cur_ch;
    assign err         = r_err;

endmodule

// File: tb/tb_idelay_bank_seq.sv
// Directed bench for idelay_bank_seq: one instance with VTC_HOLD=1 carries the
// main sequence, a second with VTC_HOLD=0 covers the EN_VTC re-enable path.
module tb_idelay_bank_seq;

    localparam int NUM_CH = 8;
    localparam int TAP_W  = 9;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rdy = 1'b0;
    logic                    err_clr = 1'b0;
    logic                    err_clr2 = 1'b0;
    logic [NUM_CH-1:0]       d = '0;
    logic [NUM_CH-1:0]       q, q2;
    logic [NUM_CH*TAP_W-1:0] load_value = '0;
    logic [NUM_CH*TAP_W-1:0] load_value2 = '0;
    logic [NUM_CH*TAP_W-1:0] dv, dv2;
    logic                    done, busy, done2, busy2;
    logic [2:0]              cur_ch, cur_ch2;
    logic [NUM_CH-1:0]       err, err2;
    logic [NUM_CH*TAP_W-1:0] fv;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_total = 0;
    int overlap = 0;
    int pulse_lane [NUM_CH] = '{default: 0};
    int pulse_order [$];
    int pulse_cyc [$];

    idelay_bank_seq #(.NUM_CH(NUM_CH), .VTC_HOLD(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .d(d), .q(q),
        .load_value(load_value), .delay_value(dv), .done(done), .busy(busy),
        .cur_ch(cur_ch), .err(err), .err_clr(err_clr)
    );

    idelay_bank_seq #(.NUM_CH(NUM_CH), .VTC_HOLD(0)) dut_h0 (
        .clk(clk), .rst(rst), .rdy(rdy), .d(d), .q(q2),
        .load_value(load_value2), .delay_value(dv2), .done(done2), .busy(busy2),
        .cur_ch(cur_ch2), .err(err2), .err_clr(err_clr2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every LOAD pulse of the main instance, mid-cycle when it is stable.
    always @(negedge clk) begin
        if (dut.r_load != '0) begin
            if ($countones(dut.r_load) > 1) overlap++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (dut.r_load[i]) begin
                    pulse_total++;
                    pulse_lane[i]++;
                    pulse_order.push_back(i);
                    pulse_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TAP_W-1:0] lane_of(input logic [NUM_CH*TAP_W-1:0] v, input int ch);
        return v[ch*TAP_W +: TAP_W];
    endfunction

    task automatic set_ch(input int ch, input logic [TAP_W-1:0] v);
        load_value[ch*TAP_W +: TAP_W] = v;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string tag);
        int k = 0;
        while ((busy !== lvl) && (k < limit)) begin
            tick(1);
            k++;
        end
        check(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k = 0;
        while ((done !== 1'b1) && (k < limit)) begin
            tick(1);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int   t0;
        int   snap;
        int   p_before;
        int   k;
        logic saw_low;
        logic saw_rise;

        // ---- reset, then rdy held low for 50 cycles ----
        tick(3);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_en_vtc", 32'(dut.r_en_vtc), 32'hFF);
        check("rst_load", 32'(dut.r_load), 32'd0);
        rst = 1'b0;
        tick(50);
        check("rdy_low_done", 32'(done), 32'd0);
        check("rdy_low_busy", 32'(busy), 32'd0);
        rdy = 1'b1;
        tick(1);
        check("idle_entry_done", 32'(done), 32'd0);
        tick(1);
        check("idle_done", 32'(done), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_dv_zero", 32'(dv == '0), 32'd1);
        check("idle_no_pulses", 32'(pulse_total), 32'd0);
        d = 8'hA5;
        #1;
        check("data_pass", 32'(q), 32'hA5);

        // ---- single load on ch3: LOAD 21 cycles in, busy 45, done one later ----
        set_ch(3, 9'd100);
        wait_busy(1'b1, 5, "t2_busy_rise");
        t0 = cyc;
        wait_busy(1'b0, 60, "t2_busy_fall");
        check("t2_busy_len", 32'(cyc - t0), 32'd45);
        check("t2_pulse_count", 32'(pulse_total), 32'd1);
        if (pulse_order.size() == 1) begin
            check("t2_pulse_lane", 32'(pulse_order[0]), 32'd3);
            check("t2_pulse_time", 32'(pulse_cyc[0] - t0), 32'd21);
        end
        check("t2_done_before", 32'(done), 32'd0);
        tick(1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_dv3", 32'(lane_of(dv, 3)), 32'd100);
        check("t2_err", 32'(err), 32'd0);
        check("t2_cur_ch", 32'(cur_ch), 32'd3);
        check("t2_en_vtc_held", 32'(dut.r_en_vtc), 32'hF7);

        // ---- ch0/5/7 together: scan from 4 gives 5, 7, then wrap to 0 ----
        pulse_order.delete();
        pulse_cyc.delete();
        set_ch(0, 9'd5);
        set_ch(5, 9'd7);
        set_ch(7, 9'd9);
        wait_busy(1'b1, 5, "t3_busy_rise");
        wait_done(200, "t3_done");
        check("t3_pulse_count", 32'(pulse_order.size()), 32'd3);
        if (pulse_order.size() == 3) begin
            check("t3_order0", 32'(pulse_order[0]), 32'd5);
            check("t3_order1", 32'(pulse_order[1]), 32'd7);
            check("t3_order2", 32'(pulse_order[2]), 32'd0);
            check("t3_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd46);
        end
        check("t3_overlap", 32'(overlap), 32'd0);
        check("t3_dv0", 32'(lane_of(dv, 0)), 32'd5);
        check("t3_dv5", 32'(lane_of(dv, 5)), 32'd7);
        check("t3_dv7", 32'(lane_of(dv, 7)), 32'd9);
        check("t3_cur_ch", 32'(cur_ch), 32'd0);
        check("t3_en_vtc", 32'(dut.r_en_vtc), 32'h56);

        // ---- readback mismatch on ch2: 50 read against target 60 ----
        fv = '0;
        fv[0*TAP_W +: TAP_W] = 9'd5;
        fv[2*TAP_W +: TAP_W] = 9'd50;
        fv[3*TAP_W +: TAP_W] = 9'd100;
        fv[5*TAP_W +: TAP_W] = 9'd7;
        fv[7*TAP_W +: TAP_W] = 9'd9;
        force dut.w_cntout = fv;
        p_before = pulse_lane[2];
        set_ch(2, 9'd60);
        wait_busy(1'b1, 5, "t4_busy_rise");
        wait_done(100, "t4_done");
        check("t4_err_set", 32'(err), 32'h04);
        check("t4_dv2_forced", 32'(lane_of(dv, 2)), 32'd50);
        check("t4_cur_ch", 32'(cur_ch), 32'd2);
        release dut.w_cntout;
        tick(2);
        check("t4_tap_loaded", 32'(lane_of(dv, 2)), 32'd60);
        tick(20);
        check("t4_err_sticky", 32'(err), 32'h04);
        check("t4_no_retry_busy", 32'(busy), 32'd0);
        check("t4_no_retry_pulses", 32'(pulse_lane[2] - p_before), 32'd1);

        // ---- rdy drops while ch1 is settling ----
        set_ch(1, 9'd33);
        wait_busy(1'b1, 5, "t5_busy_rise");
        t0 = cyc;
        tick(29);
        check("t5_ch1_loaded", 32'(pulse_lane[1]), 32'd1);
        rdy = 1'b0;
        tick(1);
        check("t5_en_vtc_all", 32'(dut.r_en_vtc), 32'hFF);
        check("t5_busy_drop", 32'(busy), 32'd0);
        check("t5_done_drop", 32'(done), 32'd0);
        check("t5_err_kept", 32'(err), 32'h04);
        tick(10);
        snap = pulse_total;
        rdy = 1'b1;
        wait_busy(1'b1, 5, "t5_busy_again");
        wait_done(400, "t5_done");
        check("t5_reload_count", 32'(pulse_total - snap), 32'd6);
        check("t5_ch1_reloaded", 32'(pulse_lane[1]), 32'd2);
        check("t5_dv1", 32'(lane_of(dv, 1)), 32'd33);
        check("t5_dv2", 32'(lane_of(dv, 2)), 32'd60);
        check("t5_dv3", 32'(lane_of(dv, 3)), 32'd100);
        check("t5_en_vtc", 32'(dut.r_en_vtc), 32'h50);
        check("t5_err_still", 32'(err), 32'h04);
        check("t5_overlap", 32'(overlap), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t5_err_clr", 32'(err), 32'd0);
        snap = pulse_total;
        tick(60);
        check("t5_no_reload", 32'(pulse_total - snap), 32'd0);
        check("t5_done_steady", 32'(done), 32'd1);

        // ---- VTC_HOLD=0 instance: single load on ch4, busy for 49 cycles ----
        load_value2[4*TAP_W +: TAP_W] = 9'd77;
        k = 0;
        while ((busy2 !== 1'b1) && (k < 5)) begin
            tick(1);
            k++;
        end
        check("t6_busy_rise", 32'(busy2), 32'd1);
        t0 = cyc;
        saw_low  = (dut_h0.r_en_vtc[4] == 1'b0);
        saw_rise = 1'b0;
        k = 0;
        while ((busy2 === 1'b1) && (k < 100)) begin
            tick(1);
            k++;
            if (dut_h0.r_en_vtc[4] == 1'b0) saw_low = 1'b1;
            if (saw_low && (dut_h0.r_en_vtc[4] == 1'b1) && (busy2 === 1'b1)) saw_rise = 1'b1;
        end
        check("t6_busy_len", 32'(cyc - t0), 32'd49);
        check("t6_vtc_low", 32'(saw_low), 32'd1);
        check("t6_vtc_rise_in_busy", 32'(saw_rise), 32'd1);
        check("t6_dv4", 32'(lane_of(dv2, 4)), 32'd77);
        check("t6_err", 32'(err2), 32'd0);
        check("t6_en_vtc", 32'(dut_h0.r_en_vtc), 32'hFF);
        tick(1);
        check("t6_done", 32'(done2), 32'd1);

        // ---- rst asserted while LOAD is high on ch6 ----
        set_ch(6, 9'd200);
        wait_busy(1'b1, 5, "t7_busy_rise");
        tick(21);
        check("t7_load_high", 32'(dut.r_load), 32'h40);
        #2;
        rst = 1'b1;
        #1;
        check("t7_load_async_drop", 32'(dut.r_load), 32'd0);
        check("t7_dv_zero", 32'(dv == '0), 32'd1);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_cur_ch", 32'(cur_ch), 32'd0);
        check("t7_en_vtc", 32'(dut.r_en_vtc), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
